// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1-style UART receiver with valid/ready output and error pulses
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int unsigned clk_rate = 100_000_000,
  parameter int unsigned Baud     = 115_200,
  parameter int unsigned Word_len = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Uart_rx,
  output logic [Word_len-1:0] rx_data,
  output logic                rx_data_valid,
  input  logic                rx_data_ready,
  output logic                frame_err,
  output logic                overrun_err,
  output logic                rx_busy
);

  localparam int unsigned BAUD_DIV = clk_rate / Baud;
  localparam int unsigned HALF_DIV = BAUD_DIV / 2;
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV) + 1;
  localparam int unsigned BIT_W    = $clog2(Word_len + 1);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(Word_len - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              state_q;
  logic                sync1_q;
  logic                rx_s_q;
  logic [CNT_W-1:0]    baud_cnt_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [Word_len-1:0] shift_q;
  logic [Word_len-1:0] data_q;
  logic                valid_q;
  logic                ferr_q;
  logic                oerr_q;
  logic                brk_q;   // bad stop already flagged; waiting for line to return high

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      oerr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      sync1_q <= Uart_rx;
      rx_s_q  <= sync1_q;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;

      if (valid_q && rx_data_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          brk_q      <= 1'b0;
          if (!rx_s_q) begin
            state_q <= S_START;
          end
        end

        S_START: begin
          if (baud_cnt_q == HALF_LAST) begin
            baud_cnt_q <= '0;
            state_q    <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            shift_q    <= {rx_s_q, shift_q[Word_len-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= S_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        S_STOP: begin
          if (brk_q) begin
            baud_cnt_q <= '0;
            if (rx_s_q) begin
              brk_q   <= 1'b0;
              state_q <= S_IDLE;
            end
          end else if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
              // A consume in this same cycle frees the slot for the new character
              if (!valid_q || rx_data_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                oerr_q <= 1'b1;
              end
            end else begin
              ferr_q <= 1'b1;
              brk_q  <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign frame_err     = ferr_q;
  assign overrun_err   = oerr_q;
  assign rx_busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : directed self-checking bench for uart_rx against a frame-level model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int unsigned CLK_RATE = 1_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned WL       = 8;
  localparam int unsigned BD       = CLK_RATE / BAUD;        // 10
  localparam int unsigned HD       = BD / 2;                 // 5
  // stop sample lands (WL+1)*BD+HD+2 after the start edge; outputs update one clock later
  localparam int unsigned LAT      = (WL + 1) * BD + HD + 2 + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         line = 1'b1;
  logic         ready = 1'b1;
  logic [7:0]   rx_data;
  logic         valid;
  logic         ferr;
  logic         oerr;
  logic         busy;

  uart_rx #(
    .clk_rate (CLK_RATE),
    .Baud     (BAUD),
    .Word_len (WL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .Uart_rx       (line),
    .rx_data       (rx_data),
    .rx_data_valid (valid),
    .rx_data_ready (ready),
    .frame_err     (ferr),
    .overrun_err   (oerr),
    .rx_busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frames the line carries; each resolves at a known cycle into a load, an overrun or a framing error
  typedef struct {
    int unsigned cyc;
    bit          good;
    logic [7:0]  ch;
  } ev_t;
  ev_t evq[$];

  logic [7:0]  obs[$];
  int unsigned obs_cyc[$];
  int unsigned n_ferr = 0;
  int unsigned n_oerr = 0;

  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       rst_p   = 1'b1;
  logic       rdy_p   = 1'b1;

  always @(negedge clk) begin : compare
    logic e_f;
    logic e_o;
    e_f = 1'b0;
    e_o = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      evq.delete();
    end else if (!rst_p) begin
      if (m_valid && rdy_p) m_valid = 1'b0;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        if (evq[0].good) begin
          if (!m_valid) begin
            m_valid = 1'b1;
            m_data  = evq[0].ch;
          end else begin
            e_o = 1'b1;
          end
        end else begin
          e_f = 1'b1;
        end
        void'(evq.pop_front());
      end
    end
    check("rx_data_valid", 32'(valid), 32'(m_valid));
    check("rx_data", 32'(rx_data), 32'(m_data));
    check("frame_err", 32'(ferr), 32'(e_f));
    check("overrun_err", 32'(oerr), 32'(e_o));
    if (rst) check("rx_busy_in_reset", 32'(busy), 32'd0);
    if (valid && ready) begin
      obs.push_back(rx_data);
      obs_cyc.push_back(cyc);
    end
    if (ferr) n_ferr++;
    if (oerr) n_oerr++;
    rst_p = rst;
    rdy_p = ready;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ch, input logic stopb);
    evq.push_back('{cyc: cyc + LAT, good: stopb, ch: ch});
    line = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      line = ch[i];
      tick(BD);
    end
    line = stopb;
    tick(BD);
  endtask

  // Drives a frame into the middle of bit 4, then resets the receiver while the line returns to idle
  task automatic send_aborted(input logic [7:0] ch);
    line = 1'b0;
    tick(BD);
    for (int i = 0; i < 4; i++) begin
      line = ch[i];
      tick(BD);
    end
    line = ch[4];
    tick(HD);
    check("busy_mid_frame", 32'(busy), 32'd1);
    rst  = 1'b1;
    line = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  logic [7:0]  exp_ch [7];
  int unsigned a5_start;

  initial begin
    exp_ch[0] = 8'hA5; exp_ch[1] = 8'h00; exp_ch[2] = 8'hFF; exp_ch[3] = 8'h3C;
    exp_ch[4] = 8'h81; exp_ch[5] = 8'h12; exp_ch[6] = 8'h7E;

    tick(4);
    rst = 1'b0;
    tick(5);
    check("busy_idle_after_reset", 32'(busy), 32'd0);

    a5_start = cyc;
    send(8'hA5, 1'b1);
    tick(20);

    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h3C, 1'b1);
    tick(20);

    line = 1'b0;
    tick(3);
    line = 1'b1;
    tick(2);
    check("busy_during_glitch", 32'(busy), 32'd1);
    tick(10);
    check("busy_after_glitch", 32'(busy), 32'd0);
    tick(10);

    send(8'h55, 1'b0);
    tick(50);
    line = 1'b1;
    tick(20);
    send(8'h81, 1'b1);
    tick(20);

    ready = 1'b0;
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    tick(20);
    check("overrun_held_valid", 32'(valid), 32'd1);
    check("overrun_held_data", 32'(rx_data), 32'h12);
    ready = 1'b1;
    tick(5);
    check("overrun_valid_dropped", 32'(valid), 32'd0);

    send_aborted(8'hC3);
    tick(20);
    send(8'h7E, 1'b1);
    tick(20);

    check("frame_err_pulses", n_ferr, 32'd1);
    check("overrun_err_pulses", n_oerr, 32'd1);
    check("transfer_count", obs.size(), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < obs.size()) check($sformatf("transfer_%0d", i), 32'(obs[i]), 32'(exp_ch[i]));
    end
    if (obs_cyc.size() > 0) check("a5_latency", obs_cyc[0] - a5_start, 32'd98);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
